// File: rtl/sram_data_ctrl_if.sv
// Memory-stage data port between the pipeline (master) and the SRAM controller (slave).
interface sram_data_ctrl_if;
    logic        req_ce;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;

    modport master (
        output req_ce, req_we, req_addr, req_sel, req_wdata,
        input  rdata, ack, stall
    );

    modport slave (
        input  req_ce, req_we, req_addr, req_sel, req_wdata,
        output rdata, ack, stall
    );
endinterface

// File: rtl/sram_data_ctrl.sv
// Turns single-cycle memory-stage requests into timed accesses on the base/ext
// asynchronous SRAMs, stalling the pipeline until the access completes.
module sram_data_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    sram_data_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              base_ce_n,
    output logic              ext_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_WR      = 3'd2,
        S_WR_HOLD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              ext_r, ext_s;
    logic [3:0]        sel_r, sel_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [2:0]        cnt_r, cnt_s;
    logic [31:0]       rdata_r, rdata_s;
    logic              ack_r, ack_s;
    logic              base_ce_n_r, base_ce_n_s;
    logic              ext_ce_n_r, ext_ce_n_s;
    logic              oe_n_r, oe_n_s;
    logic              we_n_r, we_n_s;
    logic              dq_oe_r, dq_oe_s;
    logic [3:0]        be_n_r, be_n_s;
    logic              active_s;
    logic              in_range_s;
    logic              unused_s;

    assign in_range_s = (bus.req_addr[31:23] == 9'h100);
    assign unused_s   = ^bus.req_addr[1:0];
    assign bus.stall  = bus.req_ce & in_range_s & ~ack_r;

    assign bus.rdata  = rdata_r;
    assign bus.ack    = ack_r;
    assign sram_addr  = addr_r;
    assign sram_dq_o  = wdata_r;
    assign sram_dq_oe = dq_oe_r;
    assign base_ce_n  = base_ce_n_r;
    assign ext_ce_n   = ext_ce_n_r;
    assign sram_oe_n  = oe_n_r;
    assign sram_we_n  = we_n_r;
    assign sram_be_n  = be_n_r;

    // Next-state, latched request copy, counter and read capture.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        ext_s   = ext_r;
        sel_s   = sel_r;
        wdata_s = wdata_r;
        cnt_s   = cnt_r;
        rdata_s = rdata_r;
        ack_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.req_ce && in_range_s) begin
                    addr_s  = bus.req_addr[ADDR_W+1:2];
                    ext_s   = bus.req_addr[22];
                    sel_s   = bus.req_sel;
                    wdata_s = bus.req_wdata;
                    cnt_s   = 3'(WAIT_CYCLES);
                    state_s = bus.req_we ? S_WR : S_RD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD: begin
                if (cnt_r == 3'd0) begin
                    rdata_s = sram_dq_i;
                    ack_s   = 1'b1;
                    state_s = S_DONE;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            S_WR: begin
                if (cnt_r == 3'd0) begin
                    state_s = S_WR_HOLD;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            S_WR_HOLD: begin
                ack_s   = 1'b1;
                state_s = S_DONE;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the state being entered so they line up with it.
    always_comb begin
        active_s    = (state_s == S_RD) || (state_s == S_WR) || (state_s == S_WR_HOLD);
        base_ce_n_s = ~(active_s & ~ext_s);
        ext_ce_n_s  = ~(active_s & ext_s);
        oe_n_s      = (state_s != S_RD);
        we_n_s      = (state_s != S_WR);
        dq_oe_s     = (state_s == S_WR) || (state_s == S_WR_HOLD);
        if (active_s) begin
            be_n_s = ~sel_s;
        end else begin
            be_n_s = 4'hF;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            addr_r      <= '0;
            ext_r       <= 1'b0;
            sel_r       <= 4'h0;
            wdata_r     <= 32'h0;
            cnt_r       <= 3'd0;
            rdata_r     <= 32'h0;
            ack_r       <= 1'b0;
            base_ce_n_r <= 1'b1;
            ext_ce_n_r  <= 1'b1;
            oe_n_r      <= 1'b1;
            we_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            be_n_r      <= 4'hF;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            ext_r       <= ext_s;
            sel_r       <= sel_s;
            wdata_r     <= wdata_s;
            cnt_r       <= cnt_s;
            rdata_r     <= rdata_s;
            ack_r       <= ack_s;
            base_ce_n_r <= base_ce_n_s;
            ext_ce_n_r  <= ext_ce_n_s;
            oe_n_r      <= oe_n_s;
            we_n_r      <= we_n_s;
            dq_oe_r     <= dq_oe_s;
            be_n_r      <= be_n_s;
        end
    end

endmodule
